ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test initiator for the 8Kx32 banked RAM macro; it drives the macro's CLK-domain port (WE, EN, Di, A) and checks Do.
- Runs a March C- algorithm over every word. It stops on the first mismatch and reports pass/fail plus diagnostic capture.
- Sits between the SoC test controller and the RAM. The functional/BIST port mux is outside this block.

Parameters:
- AW, 13, word address width; depth N = 2^AW.
- DW, 32, data width; WE is DW/8 bits.
- BG, 32'h0000_0000, data background D0; D1 = ~BG.

Ports:
- CLK  in  1  clock, shared with the RAM.
- RESETn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; honoured only while busy=0.
- busy  out  1  high from the cycle after an accepted start until the test ends.
- done  out  1  test finished; held until the next accepted start.
- pass  out  1  valid when done=1; 1 = no mismatch.
- fail_elem  out  3  March element index (0..5) of the first mismatch.
- fail_addr  out  AW  address of the first mismatch.
- fail_exp  out  DW  expected word at the mismatch.
- fail_got  out  DW  Do value captured at the mismatch.
- WE  out  DW/8  byte write enables to the RAM.
- EN  out  1  RAM enable.
- Di  out  DW  RAM write data.
- A  out  AW  RAM address.
- Do  in  DW  RAM read data.

Behaviour:
- RAM contract: a read is EN=1, WE=0 at edge k; Do is valid after edge k. The macro's output bank mux follows the live A, so A must be held unchanged through the cycle in which Do is checked.
- Writes always use WE = all ones (full word), EN=1.
- Reset, asynchronous: state=IDLE; busy=done=pass=0; fail_* = 0; EN=0; WE=0; A=0; Di=0. Reset mid-test aborts immediately with no partial status retained.
- March C- elements (element index = fail_elem):
  - 0 ⇑(w D0)
  - 1 ⇑(r D0, w D1)
  - 2 ⇑(r D1, w D0)
  - 3 ⇓(r D0, w D1)
  - 4 ⇓(r D1, w D0)
  - 5 ⇑(r D0)
  - ⇑ runs address 0..N-1; ⇓ runs N-1..0.
- FSM states: IDLE, WR, RD, CHK, FIN.
  - IDLE: on start, set busy=1, clear done, pass and fail_*; A=0; go to WR with element 0.
  - WR (element 0 only): EN=1, WE=all ones, Di=D0. Advance A each cycle. After address N-1, go to RD with element 1 and A=0. One cycle per address.
  - RD: EN=1, WE=0 at current A; go to CHK.
  - CHK: A held; compare Do with the element's expected read value.
    - Mismatch: EN=0, WE=0; capture fail_elem, fail_addr, fail_exp and fail_got (the Do seen in this cycle); pass=0; go to FIN.
    - Match, elements 1-4: in the same cycle issue the element's write (EN=1, WE=all ones, Di = D1 or D0) to the same A.
    - Match, element 5: EN=0.
    - Then step A (+1 or -1 per direction) and return to RD. At the last address of the element, move to the next element: A=0 for ⇑, A=N-1 for ⇓.
    - Match at the last address of element 5: pass=1, go to FIN.
  - FIN: done=1, busy=0, EN=0, WE=0; go to IDLE the next cycle. done and pass stay held in IDLE.
- Cycle count for a clean run: N + 4·2N + 2N = 11N cycles from entering WR to entering FIN. done rises at edge 11N+2 after the start edge; for AW=4 that is 178.
- A start while busy=1 is ignored.
- A start in the same cycle as FIN is ignored.
- A start in IDLE with done=1 restarts the test and clears the status.
- Address counter wraps: the ⇑ terminal is N-1 and the ⇓ terminal is 0. The counter never exceeds the AW bits.
- Outputs are registered; there is no combinational path from Do to any output except through the CHK comparison into registers.

Test Plan:
- AW=4 behavioural RAM with 1-cycle read latency and a live-A output mux, pulse start → busy=1, 176 RAM-driving cycles, then done=1, pass=1, fail_*=0. The final RAM contents are all BG.
- AW=4, address 9 bit 3 stuck-at-1 → fail in element 1 (r D0 at ⇑ address 9): done=1, pass=0, fail_elem=0x1, fail_addr=0x9, fail_exp=0x00000000, fail_got=0x00000008.
- AW=4, BG=32'hA5A5A5A5, address 2 bit 0 stuck-at-0 → fail in element 1 (expect D0 = 0xA5A5A5A5): fail_elem=0x1, fail_addr=0x2, fail_exp=0xA5A5A5A5, fail_got=0xA5A5A5A4.
- AW=4, coupling fault where a write of 1 to address 5 bit 0 sets address 4 bit 0 → caught in element 3 (⇓ reads address 4 after address 5 is written D1): fail_elem=0x3, fail_addr=0x4, fail_exp=0, fail_got=0x1.
- AW=4, assert RESETn=0 for 1 cycle during element 2 → all outputs reset immediately, with EN=0 and WE=0. A new start runs a full clean test and reaches pass=1.
- Second start pulse at cycle 50 while busy → ignored; done still rises at cycle 178.

Source files
------------

// File: rtl/ram_march_bist_if.sv
// rtl/ram_march_bist_if.sv - RAM-side port bundle between the March C- BIST and the RAM macro
//
// Signals:
//   WE  byte write enables (DW/8), driven by the BIST
//   EN  RAM enable, driven by the BIST
//   Di  write data, driven by the BIST
//   A   word address, driven by the BIST
//   Do  read data, driven by the RAM
// Modports: master = BIST side, slave = RAM side.
interface ram_march_bist_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic [DW/8-1:0] WE;
  logic            EN;
  logic [DW-1:0]   Di;
  logic [AW-1:0]   A;
  logic [DW-1:0]   Do;

  modport master (output WE, output EN, output Di, output A, input Do);
  modport slave  (input WE, input EN, input Di, input A, output Do);
endinterface

// File: rtl/ram_march_bist.sv
// rtl/ram_march_bist.sv - March C- built-in self-test initiator for the banked RAM macro
//
// Ports:
//   CLK        clock shared with the RAM
//   RESETn     asynchronous active-low reset
//   start      single-cycle start pulse, honoured only while busy=0
//   busy       test in progress
//   done       test finished, held until the next accepted start
//   pass       valid with done; 1 = no mismatch seen
//   fail_elem  March element (0..5) of the first mismatch
//   fail_addr  address of the first mismatch
//   fail_exp   expected word at the mismatch
//   fail_got   Do captured at the mismatch
//   ram        RAM port bundle (WE, EN, Di, A out; Do in)
module ram_march_bist #(
  parameter int              AW = 13,
  parameter int              DW = 32,
  parameter logic [DW-1:0]   BG = '0
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2:0]          fail_elem,
  output logic [AW-1:0]       fail_addr,
  output logic [DW-1:0]       fail_exp,
  output logic [DW-1:0]       fail_got,
  ram_march_bist_if.master    ram
);

  localparam logic [DW-1:0]   D0     = BG;
  localparam logic [DW-1:0]   D1     = ~BG;
  localparam logic [DW/8-1:0] WE_ALL = '1;
  localparam logic [AW-1:0]   A_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CHK,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     di_q, di_d;
  logic              en_q, en_d;
  logic [DW/8-1:0]   we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [AW-1:0]     fail_addr_q, fail_addr_d;
  logic [DW-1:0]     fail_exp_q, fail_exp_d;
  logic [DW-1:0]     fail_got_q, fail_got_d;

  // Element properties: 3 and 4 walk downward; 2 and 4 read D1; 1 and 3 write D1.
  logic              elem_down;
  logic              at_last;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     wr_word;
  logic              mismatch;

  assign elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign at_last   = elem_down ? (addr_q == '0) : (addr_q == A_LAST);
  assign rd_word   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? D1 : D0;
  assign wr_word   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? D1 : D0;
  assign mismatch  = (ram.Do != rd_word);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      di_q        <= '0;
      en_q        <= 1'b0;
      we_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_elem_q <= 3'd0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      en_q        <= en_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  // The RAM-facing registers carry the action of the state being entered,
  // so EN/WE/A/Di are valid for the whole cycle a state occupies.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    di_d        = di_q;
    en_d        = 1'b0;
    we_d        = '0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WR;
          elem_d      = 3'd0;
          addr_d      = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_elem_d = 3'd0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
          en_d        = 1'b1;
          we_d        = WE_ALL;
          di_d        = D0;
        end
      end

      WR: begin
        en_d = 1'b1;
        if (addr_q == A_LAST) begin
          state_d = RD;
          elem_d  = 3'd1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
          we_d   = WE_ALL;
          di_d   = D0;
        end
      end

      RD: begin
        state_d = CHK;
        // The element's write is launched on entry to CHK so it lands at the
        // end of the compare cycle; Do has already been latched by then.
        if (elem_q != 3'd5) begin
          en_d = 1'b1;
          we_d = WE_ALL;
          di_d = wr_word;
        end
      end

      CHK: begin
        if (mismatch) begin
          state_d     = FIN;
          pass_d      = 1'b0;
          fail_elem_d = elem_q;
          fail_addr_d = addr_q;
          fail_exp_d  = rd_word;
          fail_got_d  = ram.Do;
        end else if (at_last) begin
          if (elem_q == 3'd5) begin
            state_d = FIN;
            pass_d  = 1'b1;
          end else begin
            state_d = RD;
            elem_d  = elem_q + 3'd1;
            // Elements 3 and 4 (entered from 2 and 3) start from the top.
            addr_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? A_LAST : '0;
            en_d    = 1'b1;
          end
        end else begin
          state_d = RD;
          addr_d  = elem_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
          en_d    = 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_elem = fail_elem_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;
  assign ram.EN    = en_q;
  assign ram.WE    = we_q;
  assign ram.A     = addr_q;
  assign ram.Di    = di_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// tb/tb_ram_march_bist.sv - scoreboard bench for ram_march_bist with a faultable behavioural RAM
module tb_ram_march_bist;

  localparam int N = 16;

  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  always #5 CLK = ~CLK;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0]  fe0, fe1;
  logic [3:0]  fa0, fa1;
  logic [31:0] fx0, fg0, fx1, fg1;

  ram_march_bist_if #(.AW(4), .DW(32)) ram0 ();
  ram_march_bist_if #(.AW(4), .DW(32)) ram1 ();

  ram_march_bist #(.AW(4), .DW(32), .BG(32'h0000_0000)) dut0 (
    .CLK(CLK), .RESETn(RESETn), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_elem(fe0), .fail_addr(fa0), .fail_exp(fx0), .fail_got(fg0), .ram(ram0)
  );

  ram_march_bist #(.AW(4), .DW(32), .BG(32'hA5A5_A5A5)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_elem(fe1), .fail_addr(fa1), .fail_exp(fx1), .fail_got(fg1), .ram(ram1)
  );

  // 0 none, 1 addr 9 bit 3 stuck-at-1, 2 addr 2 bit 0 stuck-at-0,
  // 3 write of 1 to addr 5 bit 0 also sets addr 4 bit 0
  int fault_mode = 0;

  function automatic logic [31:0] fault_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (fault_mode == 1 && a == 4'd9) r[3] = 1'b1;
    if (fault_mode == 2 && a == 4'd2) r[0] = 1'b0;
    return r;
  endfunction

  // RAM model: read snapshots all banks at the read edge; Do muxes by live A.
  logic [31:0] mem0 [N];
  logic [31:0] snap0 [N];
  logic [31:0] mem1 [N];
  logic [31:0] snap1 [N];

  always @(posedge CLK) begin
    if (ram0.EN) begin
      if (ram0.WE == 4'hF) begin
        mem0[ram0.A] <= fault_wr(ram0.A, ram0.Di);
        if (fault_mode == 3 && ram0.A == 4'd5 && ram0.Di[0]) mem0[4][0] <= 1'b1;
      end else if (ram0.WE == 4'h0) begin
        snap0 <= mem0;
      end
    end
    if (ram1.EN) begin
      if (ram1.WE == 4'hF) mem1[ram1.A] <= fault_wr(ram1.A, ram1.Di);
      else if (ram1.WE == 4'h0) snap1 <= mem1;
    end
  end

  assign ram0.Do = snap0[ram0.A];
  assign ram1.Do = snap1[ram1.A];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        pass;
    logic [2:0]  elem;
    logic [3:0]  addr;
    logic [31:0] exp;
    logic [31:0] got;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic p, input logic [2:0] e, input logic [3:0] a,
                              input logic [31:0] x, input logic [31:0] g, input int dc);
    exp_t r;
    r.pass = p; r.elem = e; r.addr = a; r.exp = x; r.got = g; r.done_cyc = dc;
    return r;
  endfunction

  // Edge (counted from the edge after start is raised as edge 0) at which done
  // rises for a mismatch at element elem (1..5), address addr: element 0 spends
  // edges 1..N, every later address takes RD+CHK, then FIN, then done.
  function automatic int exp_done(input int elem, input int addr);
    int pos;
    pos = (elem == 3 || elem == 4) ? (N - 1 - addr) : addr;
    return N + 1 + 2 * N * (elem - 1) + 2 * pos + 3;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  task automatic run_test(input int sel, input exp_t e, input bit dbl_start);
    exp_t r;
    int   cyc;
    bit   seen;
    logic d_busy, d_done;
    @(posedge CLK); #1;
    sb.push_back(e);
    set_start(sel, 1'b1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge CLK); #1;
      cyc++;
      if (cyc == 1) begin
        set_start(sel, 1'b0);
        check("busy_after_start", (sel == 0) ? busy0 : busy1, 1);
        check("done_cleared", (sel == 0) ? done0 : done1, 0);
      end
      if (dbl_start && cyc == 49) set_start(sel, 1'b1);
      if (dbl_start && cyc == 50) set_start(sel, 1'b0);
      if (((sel == 0) ? done0 : done1) == 1'b1) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    r = sb.pop_front();
    check("pass",      (sel == 0) ? pass0 : pass1, r.pass);
    check("fail_elem", (sel == 0) ? fe0 : fe1, r.elem);
    check("fail_addr", (sel == 0) ? fa0 : fa1, r.addr);
    check("fail_exp",  (sel == 0) ? fx0 : fx1, r.exp);
    check("fail_got",  (sel == 0) ? fg0 : fg1, r.got);
    check("done_cycle", cyc, r.done_cyc);
    repeat (3) @(posedge CLK);
    #1;
    d_busy = (sel == 0) ? busy0 : busy1;
    d_done = (sel == 0) ? done0 : done1;
    check("idle_busy", d_busy, 0);
    check("done_held", d_done, 1);
  endtask

  initial begin
    #3 RESETn = 1'b0;
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_en", ram0.EN, 0);
    check("rst_we", ram0.WE, 0);
    check("rst_a", ram0.A, 0);
    check("rst_di", ram0.Di, 0);
    check("rst_fail_got", fg0, 0);
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;

    // Clean run, then all words must hold the background.
    fault_mode = 0;
    run_test(0, mk(1'b1, 3'd0, 4'd0, 32'h0, 32'h0, 11 * N + 2), 1'b0);
    for (int i = 0; i < N; i++) check($sformatf("final_mem%0d", i), mem0[i], 32'h0);

    // Restart from done=1 with a stuck-at-1 cell.
    fault_mode = 1;
    run_test(0, mk(1'b0, 3'd1, 4'd9, 32'h0, 32'h8, exp_done(1, 9)), 1'b0);

    // Non-zero background, stuck-at-0 cell.
    fault_mode = 2;
    run_test(1, mk(1'b0, 3'd1, 4'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A4, exp_done(1, 2)), 1'b0);

    // Coupling fault caught on the downward pass.
    fault_mode = 3;
    run_test(0, mk(1'b0, 3'd3, 4'd4, 32'h0, 32'h1, exp_done(3, 4)), 1'b0);

    // Reset during element 2 aborts everything.
    fault_mode = 0;
    @(posedge CLK); #1;
    start0 = 1'b1;
    @(posedge CLK); #1;
    start0 = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    check("mid_busy", busy0, 1);
    RESETn = 1'b0;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_en", ram0.EN, 0);
    check("abort_we", ram0.WE, 0);
    check("abort_a", ram0.A, 0);
    check("abort_fail_elem", fe0, 0);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    run_test(0, mk(1'b1, 3'd0, 4'd0, 32'h0, 32'h0, 11 * N + 2), 1'b0);

    // Second start while busy is ignored.
    run_test(0, mk(1'b1, 3'd0, 4'd0, 32'h0, 32'h0, 11 * N + 2), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
